mask_stream_reader: RTL
=======================

Name: mask_stream_reader

Overview:
- Reads the finished binary mask frame out of the mask BRAM after erosion/dilation completes, one WIDTH-bit row per read.
- Serializes each row into a one-pixel-per-beat stream with x/y coordinates for downstream consumers (centroid/bounding-box logic, display overlay).
- Uses a separate read port (B) of the same BRAM, so it never contends with the morphology engine on port A.
- Double-buffers rows so a full frame streams without bubbles when the sink is always ready.

Parameters:
WIDTH, 640, pixels per row = BRAM word width
HEIGHT, 480, rows per frame
ADDR_W, 9, BRAM address width
X_W, 10, width of pix_x
RD_LAT, 2, BRAM read latency in cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  level request, typically finish_ed; async to logic, synchronized internally
doutb  in  WIDTH  BRAM port B read data
addrb  out  ADDR_W  BRAM port B address
enb  out  1  BRAM port B enable (read only; write enable tied low outside)
pix_data  out  1  mask pixel = bit pix_x of row pix_y
pix_x  out  X_W  column 0..WIDTH-1
pix_y  out  ADDR_W  row 0..HEIGHT-1
pix_eol  out  1  high on beat with pix_x==WIDTH-1
pix_last  out  1  high on beat with pix_x==WIDTH-1 and pix_y==HEIGHT-1
pix_valid  out  1  beat valid
pix_ready  in  1  sink accepts beat
busy  out  1  frame in progress
done  out  1  frame fully transferred

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; both sync flops 0; state IDLE; both row buffers 0; cur_valid and nxt_valid 0.
- start passes through two flops (start_s). Whenever start_s==0 outside IDLE: synchronous abort to IDLE next cycle. Abort clears pix_valid, enb, busy, done and all buffer-valid flags.
- States: IDLE, FETCH, STREAM, DONE.
- Frame start: E0 = first cycle in IDLE with start_s==1. Go to FETCH, set busy=1, set fetch row index fy=0.
- Read protocol: drive addrb=fy and enb=1 for RD_LAT+1 consecutive cycles, with an internal counter 0..RD_LAT.
  - When the counter==RD_LAT, capture doutb into the target buffer; then enb=0 and fy increments.
  - Only one read is outstanding at a time.
  - First read starts at E0+1. Row 0 is captured at the end of cycle E0+1+RD_LAT.
  - pix_valid first rises in cycle E0+2+RD_LAT with pix_x=0, pix_y=0.
- STREAM: pix_data = cur[pix_x]; coordinates, pix_eol and pix_last are combinational from counters.
  - A beat transfers when pix_valid && pix_ready.
  - While pix_valid && !pix_ready, pix_data, pix_x, pix_y, pix_eol and pix_last are held stable.
- Prefetch: in STREAM, when nxt_valid==0 and fy<HEIGHT, issue the next read into nxt. Never fetch more than one row ahead.
- Row boundary: on transfer of a pix_eol beat that is not pix_last:
  - If nxt_valid: cur<=nxt, nxt_valid<=0, pix_x<=0, pix_y+1, and pix_valid stays high (no bubble).
  - Else: pix_valid drops until the outstanding read captures into nxt, then promote the row the same way.
- Frame end: on transfer of the pix_last beat, pix_valid<=0 and go to DONE next cycle, with done=1, busy=0, enb=0.
  - Hold DONE until start_s==0, then IDLE.
  - No second frame starts without start_s falling then rising again.
- Throughput: with pix_ready constantly 1, exactly WIDTH*HEIGHT contiguous beats (no gaps after the first).
- Counters never wrap: pix_x resets at WIDTH-1 on eol; fy saturates at HEIGHT.
- Simultaneous events: abort has priority over any transfer or capture in the same cycle. A capture and a row promotion in the same cycle is legal; the capture targets nxt only after the promotion has freed it.

Test Plan:
- Reset: hold rst low with start=1 and random doutb -> every output 0 and enb never 1; after release with start=0 -> outputs stay 0.
- Full frame: BRAM model (RD_LAT=2) with row y = {WIDTH/32{y,~y[... ] pattern}}, pix_ready=1, start rising -> first valid at E0+4; 307200 contiguous beats; pix_data matches the model; pix_eol on every x=639; single pix_last at (639,479); done the cycle after.
- Backpressure: random pix_ready at 30% high -> no beat lost or duplicated; outputs stable while stalled; beat count still 307200.
- Boundary stall: hold pix_ready=0 for 2000 cycles at x=639, y=10 -> exactly one prefetch read (addrb=11) and no read of 12 until row 11 is promoted.
- Abort: drop start at y=200, x=300 -> within 3 cycles pix_valid=0, enb=0, busy=0, done=0; re-raise start -> stream restarts at (0,0) with addrb=0 first.
- Async reset mid-stream: pull rst low between clock edges at y=5 -> outputs 0 immediately without a clock edge; frame restarts cleanly on the next start edge.

Source files
------------

// File: rtl/mask_stream_reader.sv
// mask_stream_reader
// ------------------
// Reads a finished binary mask frame out of the mask BRAM (read-only port B)
// one WIDTH-bit row per read, and serialises it as one pixel per beat with
// x/y coordinates. A current-row buffer feeds the stream while a next-row
// buffer is prefetched, so with an always-ready sink a whole frame leaves as
// WIDTH*HEIGHT contiguous beats after the initial fetch latency.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-low reset
//   start      level request (async source, synchronised internally);
//              dropping it outside IDLE aborts the frame
//   doutb      BRAM port B read data (RD_LAT cycles after addrb/enb)
//   addrb      BRAM port B address (row index)
//   enb        BRAM port B enable
//   pix_data   mask pixel = bit pix_x of row pix_y
//   pix_x      column 0..WIDTH-1
//   pix_y      row 0..HEIGHT-1
//   pix_eol    beat is the last pixel of a row
//   pix_last   beat is the last pixel of the frame
//   pix_valid  beat valid
//   pix_ready  sink accepts beat
//   busy       frame in progress
//   done       frame fully transferred (held until start falls)

module mask_stream_reader #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 9,
  parameter int X_W    = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  doutb,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  output logic              pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [ADDR_W-1:0] pix_y,
  output logic              pix_eol,
  output logic              pix_last,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);

  // Read counter runs 0..RD_LAT; keep at least one bit even for RD_LAT==0.
  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(RD_LAT);
  localparam logic [X_W-1:0]    X_LAST  = X_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] Y_END   = ADDR_W'(HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // start synchroniser
  logic start_meta_r;
  logic start_sync_r;

  // Row buffers and their valid flags
  logic [WIDTH-1:0] cur_r;
  logic [WIDTH-1:0] nxt_r;
  logic             cur_valid_r;
  logic             nxt_valid_r;
  logic             row_wait_r;   // eol beat taken before next row arrived

  // Read engine
  logic [ADDR_W-1:0] fy_r;        // next row to fetch, saturates at HEIGHT
  logic [CNT_W-1:0]  rd_cnt_r;
  logic              rd_to_cur_r; // outstanding read targets cur (first row)
  logic              enb_r;
  logic [ADDR_W-1:0] addrb_r;

  // Stream side
  logic [X_W-1:0]    pix_x_r;
  logic [ADDR_W-1:0] pix_y_r;
  logic              pix_valid_r;
  logic              busy_r;
  logic              done_r;

  // Control strobes
  logic abort_s;
  logic frame_go_s;
  logic at_eol_s;
  logic at_last_s;
  logic xfer_s;
  logic capture_s;
  logic cap_cur_s;
  logic cap_nxt_s;
  logic end_beat_s;
  logic promote_s;
  logic row_stall_s;
  logic issue_s;

  // Two-flop synchroniser for the asynchronous start level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
    end else begin
      start_meta_r <= start;
      start_sync_r <= start_meta_r;
    end
  end

  // Event decode shared by the FSM and the datapath registers.
  always_comb begin
    abort_s     = (state_r != ST_IDLE) && !start_sync_r;
    frame_go_s  = (state_r == ST_IDLE) && start_sync_r;
    at_eol_s    = (pix_x_r == X_LAST);
    at_last_s   = at_eol_s && (pix_y_r == Y_LAST);
    xfer_s      = !abort_s && (state_r == ST_STREAM) && pix_valid_r &&
                  cur_valid_r && pix_ready;
    capture_s   = !abort_s && enb_r && (rd_cnt_r == RD_LAST);
    cap_cur_s   = capture_s && rd_to_cur_r;
    cap_nxt_s   = capture_s && !rd_to_cur_r;
    end_beat_s  = xfer_s && at_last_s;
    // Promotion either rides the eol transfer (no bubble) or ends a wait.
    promote_s   = !abort_s && nxt_valid_r &&
                  ((xfer_s && at_eol_s && !at_last_s) || row_wait_r);
    row_stall_s = xfer_s && at_eol_s && !at_last_s && !nxt_valid_r;
    // One read in flight at most; prefetch only into an empty nxt buffer.
    issue_s     = frame_go_s ||
                  (!abort_s && (state_r == ST_STREAM) && !enb_r &&
                   !nxt_valid_r && (fy_r < Y_END) && !end_beat_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; abort outranks every other event.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_go_s) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cap_cur_s) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_STREAM: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (end_beat_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // BRAM read engine: hold addrb/enb for RD_LAT+1 cycles, capture on the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enb_r       <= 1'b0;
      addrb_r     <= {ADDR_W{1'b0}};
      rd_cnt_r    <= {CNT_W{1'b0}};
      rd_to_cur_r <= 1'b0;
      fy_r        <= {ADDR_W{1'b0}};
    end else if (abort_s) begin
      enb_r    <= 1'b0;
      rd_cnt_r <= {CNT_W{1'b0}};
    end else if (issue_s) begin
      enb_r       <= 1'b1;
      rd_cnt_r    <= {CNT_W{1'b0}};
      rd_to_cur_r <= frame_go_s;
      if (frame_go_s) begin
        addrb_r <= {ADDR_W{1'b0}};
        fy_r    <= {ADDR_W{1'b0}};
      end else begin
        addrb_r <= fy_r;
      end
    end else if (capture_s) begin
      enb_r    <= 1'b0;
      rd_cnt_r <= {CNT_W{1'b0}};
      if (fy_r < Y_END) begin
        fy_r <= fy_r + ADDR_W'(1'b1);
      end else begin
        fy_r <= fy_r;
      end
    end else if (end_beat_s) begin
      enb_r <= 1'b0;
    end else if (enb_r) begin
      rd_cnt_r <= rd_cnt_r + CNT_W'(1'b1);
    end else begin
      rd_cnt_r <= rd_cnt_r;
    end
  end

  // Row buffers. Promotion frees nxt in the same cycle a capture may refill it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_r       <= {WIDTH{1'b0}};
      nxt_r       <= {WIDTH{1'b0}};
      cur_valid_r <= 1'b0;
      nxt_valid_r <= 1'b0;
      row_wait_r  <= 1'b0;
    end else if (abort_s) begin
      cur_valid_r <= 1'b0;
      nxt_valid_r <= 1'b0;
      row_wait_r  <= 1'b0;
    end else begin
      if (cap_cur_s) begin
        cur_r       <= doutb;
        cur_valid_r <= 1'b1;
      end else if (promote_s) begin
        cur_r <= nxt_r;
      end else if (end_beat_s) begin
        cur_valid_r <= 1'b0;
      end else begin
        cur_r <= cur_r;
      end

      if (cap_nxt_s) begin
        nxt_r <= doutb;
      end else begin
        nxt_r <= nxt_r;
      end
      nxt_valid_r <= (nxt_valid_r && !promote_s) || cap_nxt_s;

      if (row_stall_s) begin
        row_wait_r <= 1'b1;
      end else if (promote_s) begin
        row_wait_r <= 1'b0;
      end else begin
        row_wait_r <= row_wait_r;
      end
    end
  end

  // Stream counters, beat valid and frame status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_x_r     <= {X_W{1'b0}};
      pix_y_r     <= {ADDR_W{1'b0}};
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (abort_s) begin
      pix_x_r     <= {X_W{1'b0}};
      pix_y_r     <= {ADDR_W{1'b0}};
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (frame_go_s || end_beat_s) begin
        pix_x_r <= {X_W{1'b0}};
        pix_y_r <= {ADDR_W{1'b0}};
      end else if (promote_s) begin
        pix_x_r <= {X_W{1'b0}};
        pix_y_r <= pix_y_r + ADDR_W'(1'b1);
      end else if (xfer_s && !at_eol_s) begin
        pix_x_r <= pix_x_r + X_W'(1'b1);
      end else begin
        // eol taken without a next row: park on the eol coordinates
        pix_x_r <= pix_x_r;
      end

      if (cap_cur_s || promote_s) begin
        pix_valid_r <= 1'b1;
      end else if (end_beat_s || row_stall_s) begin
        pix_valid_r <= 1'b0;
      end else begin
        pix_valid_r <= pix_valid_r;
      end

      if (frame_go_s) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else if (end_beat_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
        done_r <= done_r;
      end
    end
  end

  // Pixel and flags are gated by valid so idle/bubble cycles read as zero.
  assign pix_data  = pix_valid_r & cur_r[pix_x_r];
  assign pix_eol   = pix_valid_r & at_eol_s;
  assign pix_last  = pix_valid_r & at_last_s;
  assign pix_x     = pix_x_r;
  assign pix_y     = pix_y_r;
  assign pix_valid = pix_valid_r;
  assign addrb     = addrb_r;
  assign enb       = enb_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
